// File: rtl/float_to_fixed_seq.sv
// Iterative IEEE-754 single -> 32-bit two's-complement fixed-point converter, one shift per cycle.
// Optional macro ROUND_NEAREST_EN: round-to-nearest-even on right shifts (default build truncates).
module float_to_fixed_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      float_in,
  input  logic [4:0]       fixpointpos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      fixed_out,
  output logic             overflow,
  output logic [CNT_W-1:0] conv_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] SIGN   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mag;
    logic [4:0]  fp;
  } req_t;

  req_t               req;
  logic [2:0]         state;
  logic [31:0]        acc;
  logic [4:0]         cnt;
  logic               left;
  logic               sat;
  logic signed [9:0]  s;
  logic [4:0]         s_abs;
  logic               rnd;
  logic [31:0]        mag_r;

  // s is the net left-shift applied to the 24-bit significand
  assign s     = $signed({2'b00, req.exp}) + $signed({5'b00000, req.fp}) - 10'sd150;
  assign s_abs = s[9] ? 5'(-s) : 5'(s);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef ROUND_NEAREST_EN
  logic guard, sticky;

  // guard is the last bit shifted out; sticky ORs everything shifted out before it
  always_ff @(posedge clk) begin
    if (!rst) begin
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else if (state == UNPACK) begin
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else if (state == SHIFT && !left) begin
      guard  <= acc[0];
      sticky <= sticky | guard;
    end
  end

  assign rnd = guard & (sticky | acc[0]);
`else
  assign rnd = 1'b0;
`endif

  // rounding only happens after right shifts, so acc < 2^24 and this cannot wrap
  assign mag_r = acc + {31'b0, rnd};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      acc        <= '0;
      cnt        <= '0;
      left       <= 1'b0;
      sat        <= 1'b0;
      fixed_out  <= '0;
      overflow   <= 1'b0;
      conv_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            req.sign <= float_in[31];
            req.exp  <= float_in[30:23];
            req.mag  <= {1'b1, float_in[22:0]};
            req.fp   <= fixpointpos;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          sat   <= 1'b0;
          acc   <= {8'b0, req.mag};
          cnt   <= s_abs;
          left  <= ~s[9];
          state <= SHIFT;
          if (req.exp == 8'h00) begin
            acc   <= '0;
            state <= SIGN;
          end else if (req.exp == 8'hFF || s >= 10'sd9 ||
                       (s == 10'sd8 && (!req.sign || req.mag[22:0] != 23'b0))) begin
            // -2^31 is the only representable s==8 value; everything else saturates
            sat   <= 1'b1;
            state <= SIGN;
          end else if (s < -10'sd24) begin
            acc   <= '0;
            state <= SIGN;
          end else if (s == 10'sd0) begin
            state <= SIGN;
          end
        end
        SHIFT: begin
          acc <= left ? (acc << 1) : (acc >> 1);
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= SIGN;
        end
        SIGN: begin
          if (sat) fixed_out <= req.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          else     fixed_out <= req.sign ? -mag_r : mag_r;
          overflow <= sat;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (!(&conv_count)) conv_count <= conv_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Directed bench for float_to_fixed_seq: driver pushes expected results, monitor pops on output handshake.
module tb_float_to_fixed_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] float_in = '0;
  logic [4:0]  fixpointpos = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] fixed_out;
  logic        overflow;
  logic [15:0] conv_count;

  float_to_fixed_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float_in(float_in), .fixpointpos(fixpointpos), .out_valid(out_valid),
    .out_ready(out_ready), .fixed_out(fixed_out), .overflow(overflow),
    .conv_count(conv_count)
  );

  always #5 clk = ~clk;

`ifdef ROUND_NEAREST_EN
  localparam bit RN = 1'b1;
`else
  localparam bit RN = 1'b0;
`endif

  typedef struct {
    logic [31:0] fx;
    logic        ov;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst && out_valid && !prev_v) rise_cyc = cyc;
    prev_v = out_valid;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%08h want none", fixed_out);
      end else begin
        me = sb.pop_front();
        chk("fixed_out", fixed_out, me.fx);
        chk("overflow", {31'b0, overflow}, {31'b0, me.ov});
        chk("latency", 32'(rise_cyc - me.acc_cyc), 32'(me.lat));
        n_done++;
      end
    end
  end

  task automatic issue(input logic [31:0] f, input logic [4:0] fp, input logic [31:0] fx,
                       input logic ov, input int lat, input bit push);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) tmo("in_ready");
    float_in    = f;
    fixpointpos = fp;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.fx = fx;
    e.ov = ov;
    e.acc_cyc = cyc;
    e.lat = lat;
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (sb.size() != 0) tmo("drain");
    chk("conv_count", 32'(conv_count), 32'(n_done));
  endtask

  task automatic run(input logic [31:0] f, input logic [4:0] fp, input logic [31:0] fx,
                     input logic ov, input int lat);
    issue(f, fp, fx, ov, lat, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_fixed_out", fixed_out, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_conv_count", 32'(conv_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run(32'h3FC0_0000, 5'd16, 32'h0001_8000, 1'b0, 9);    // 1.5, s=-7
    run(32'hC049_0FDB, 5'd8,  32'hFFFF_FCDC, 1'b0, 16);   // -pi, s=-14
    run(32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 2);    // 2^31 saturates
    run(32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b0, 10);   // -2^31 exact
    run(32'h7F80_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 2);    // +inf
    run(32'hFF80_0000, 5'd3,  32'h8000_0000, 1'b1, 2);    // -inf
    run(32'h7FC0_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 2);    // NaN
    run(32'h0000_0000, 5'd5,  32'h0000_0000, 1'b0, 2);
    run(32'h8000_0000, 5'd31, 32'h0000_0000, 1'b0, 2);
    run(32'h3F80_0000, 5'd23, 32'h0080_0000, 1'b0, 2);    // s==0
    run(32'h3F80_0000, 5'd30, 32'h4000_0000, 1'b0, 9);    // s=7
    run(32'h3F80_0000, 5'd31, 32'h7FFF_FFFF, 1'b1, 2);    // +1.0, s=8
    run(32'hBF80_0000, 5'd31, 32'h8000_0000, 1'b0, 10);   // -1.0, s=8
    run(32'hBFC0_0000, 5'd31, 32'h8000_0000, 1'b1, 2);    // -1.5, s=8
    run(32'h3300_0000, 5'd0,  32'h0000_0000, 1'b0, 2);    // s<-24
    run(32'h3F40_0000, 5'd0,  RN ? 32'd1 : 32'd0, 1'b0, 26);  // 0.75, s=-24
    run(32'h3F00_0000, 5'd0,  32'd0, 1'b0, 26);               // 0.5 tie to even
    run(32'h3FE0_0000, 5'd0,  RN ? 32'd2 : 32'd1, 1'b0, 25);  // 1.75
    run(32'h4020_0000, 5'd0,  32'd2, 1'b0, 24);               // 2.5 tie to even
    run(32'h4060_0000, 5'd0,  RN ? 32'd4 : 32'd3, 1'b0, 24);  // 3.5
    run(32'hBFE0_0000, 5'd0,  RN ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b0, 25); // -1.75

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    issue(32'hC049_0FDB, 5'd8, 32'hFFFF_FCDC, 1'b0, 16, 1'b1);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) tmo("bp_out_valid");
    repeat (5) begin
      @(negedge clk);
      chk("bp_fixed_out", fixed_out, 32'hFFFF_FCDC);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    drain();

    // reset mid-SHIFT: nothing stale may come out afterwards
    issue(32'h3FC0_0000, 5'd0, 32'd1, 1'b0, 25, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_done = 0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_conv_count", 32'(conv_count), 32'd0);
    chk("abort_fixed_out", fixed_out, 32'd0);
    repeat (40) @(negedge clk);
    run(32'h3FC0_0000, 5'd16, 32'h0001_8000, 1'b0, 9);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) tmo("final_queue");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
